// File: rtl/hex_scan_display.sv
// hex_scan_display
//
// Seven-segment display engine for the CPU board. A load strobe captures a
// packed hex value, per-digit masks and the leading-zero enable into a shadow
// register. Every display path decodes from that shadow register, never from
// the live inputs.
//
// The shadow register drives two output paths:
//   - hex_static : a registered static bus with one 7-bit group per digit
//   - scan_seg / scan_an : a time-multiplexed port with one shared segment bus
//     and one-hot, active-low anodes. Each digit slot lasts SCAN_DIV cycles,
//     and the last cycle of every slot is dark.
// frame_tick pulses for one cycle after each complete scan of all digits.
//
// Segment patterns are active-low with bit order {g,f,e,d,c,b,a}.
// Per-digit priority, highest first: dash, blank, blink-off, leading zero, hex.
//
// Optional feature macro: HEX_SCAN_BLINK_EN
//   defined   -> frame counter and blink phase are built; blink_mask is honoured.
//   undefined -> blink_mask is captured but no digit ever blinks.
//
// Parameters:
//   NUM_DIGITS  number of digits (1..16)
//   SCAN_DIV    light_clk cycles per scan slot (>= 2)
//   BLINK_DIV   scan frames per blink half-period (>= 1)
//
// Ports:
//   light_clk   sole clock, rising edge
//   rst         asynchronous, active-high reset
//   value       NUM_DIGITS nibbles, nibble i = digit i (digit 0 least significant)
//   load        capture all inputs below into the shadow register
//   blank_mask  per-digit forced blank
//   dash_mask   per-digit forced '-'
//   blink_mask  per-digit blink enable
//   lz_en       leading-zero suppression enable
//   hex_static  bits [7i+6:7i] drive digit i
//   scan_seg    shared segment bus for the scan port
//   scan_an     one-hot, active-low anode selects
//   frame_tick  one-cycle pulse at the end of each full scan

module hex_scan_display #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 25
) (
    input  logic                      light_clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS*4-1:0]   value,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     dash_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_en,
    output logic [NUM_DIGITS*7-1:0]   hex_static,
    output logic [6:0]                scan_seg,
    output logic [NUM_DIGITS-1:0]     scan_an,
    output logic                      frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Shadow register: the only copy of display data the decoders ever see
    logic [NUM_DIGITS*4-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_dash;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz;

    // Scan sequencer state
    logic [PRE_W-1:0] prescaler;
    logic [IDX_W-1:0] slot_idx;
    logic             pre_last;
    logic             slot_last;
    logic             frame_end;

    // Decode intermediates
    logic                    blink_phase;
    logic [NUM_DIGITS-1:0]   blink_off;
    logic [NUM_DIGITS-1:0]   lz_suppress;
    logic                    upper_zero;
    logic [6:0]              digit_pat [NUM_DIGITS];
    logic [NUM_DIGITS*7-1:0] static_next;
    logic [6:0]              scan_pat;
    logic [NUM_DIGITS-1:0]   scan_an_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Capture the display request; nothing here touches the scan timing
    always_ff @(posedge light_clk or posedge rst) begin
        if (rst) begin
            sh_value <= '0;
            sh_blank <= '0;
            sh_dash  <= '0;
            sh_blink <= '0;
            sh_lz    <= 1'b0;
        end else if (load) begin
            sh_value <= value;
            sh_blank <= blank_mask;
            sh_dash  <= dash_mask;
            sh_blink <= blink_mask;
            sh_lz    <= lz_en;
        end
    end

    assign pre_last  = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign slot_last = (slot_idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_end = pre_last & slot_last;

`ifdef HEX_SCAN_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] frame_cnt;

    // Count completed frames and flip the blink phase every BLINK_DIV of them.
    // The frame_end edge is the same edge that raises frame_tick.
    always_ff @(posedge light_clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (frame_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + BLINK_W'(1);
            end
        end
    end
`else
    // Without blink support the phase is permanently on. BLINK_DIV is folded
    // in so the parameter stays referenced in this build.
    assign blink_phase = 1'b1 | (BLINK_DIV < 1);
`endif

    assign blink_off = sh_blink & {NUM_DIGITS{~blink_phase}};

    // Leading-zero test walks from the top digit down. A digit is suppressed
    // only while every nibble at or above it is zero. Masks do not affect the
    // test, and digit 0 always shows.
    always_comb begin
        upper_zero  = 1'b1;
        lz_suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero     = upper_zero & (sh_value[4*i +: 4] == 4'h0);
            lz_suppress[i] = sh_lz & upper_zero & (i != 0);
        end
    end

    // Per-digit pattern with dash > blank > blink-off > leading zero > hex
    always_comb begin
        static_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sh_dash[i]) begin
                digit_pat[i] = SEG_DASH;
            end else if (sh_blank[i] | blink_off[i] | lz_suppress[i]) begin
                digit_pat[i] = SEG_BLANK;
            end else begin
                digit_pat[i] = hex_to_seg(sh_value[4*i +: 4]);
            end
            static_next[7*i +: 7] = digit_pat[i];
        end
    end

    // Static bus is one register stage behind the shadow
    always_ff @(posedge light_clk or posedge rst) begin
        if (rst) begin
            hex_static <= '1;
        end else begin
            hex_static <= static_next;
        end
    end

    // Select the pattern and anode for the current slot
    always_comb begin
        scan_pat    = SEG_BLANK;
        scan_an_lit = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_idx == IDX_W'(i)) begin
                scan_pat       = digit_pat[i];
                scan_an_lit[i] = 1'b0;
            end
        end
    end

    // Scan sequencer. The final prescaler count of every slot is a dark
    // cycle: the anodes switch while every segment is off, so the next digit
    // never shows the previous digit's pattern.
    always_ff @(posedge light_clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            slot_idx   <= '0;
            scan_an    <= '1;
            scan_seg   <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (pre_last) begin
                prescaler <= '0;
                scan_an   <= '1;
                scan_seg  <= SEG_BLANK;
                slot_idx  <= slot_last ? '0 : slot_idx + IDX_W'(1);
            end else begin
                prescaler <= prescaler + PRE_W'(1);
                scan_an   <= scan_an_lit;
                scan_seg  <= scan_pat;
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display
//
// Self-checking bench for hex_scan_display with NUM_DIGITS=4, SCAN_DIV=4 and
// BLINK_DIV=2. It runs four parts:
//   - a table of static-decode vectors
//   - hand-written reset and async-reset checks
//   - a cycle-by-cycle scan timeline
//   - a blink timeline
// Expectations follow HEX_SCAN_BLINK_EN in the same way the design does.

module tb_hex_scan_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 2;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD_ = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;

    logic          light_clk;
    logic          rst;
    logic [15:0]   value;
    logic          load;
    logic [3:0]    blank_mask;
    logic [3:0]    dash_mask;
    logic [3:0]    blink_mask;
    logic          lz_en;
    logic [27:0]   hex_static;
    logic [6:0]    scan_seg;
    logic [3:0]    scan_an;
    logic          frame_tick;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic [3:0]  dash;
        logic        lz;
        logic [27:0] expected;
    } vec_t;

    vec_t vecs [12];

    hex_scan_display #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .light_clk  (light_clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .blank_mask (blank_mask),
        .dash_mask  (dash_mask),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .hex_static (hex_static),
        .scan_seg   (scan_seg),
        .scan_an    (scan_an),
        .frame_tick (frame_tick)
    );

    initial light_clk = 1'b0;
    always #5 light_clk = ~light_clk;

    // Drive a load on one posedge and return on the following negedge
    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] bm,
                                 input logic [3:0] dm, input logic [3:0] km,
                                 input logic lz);
        @(negedge light_clk);
        value      = v;
        blank_mask = bm;
        dash_mask  = dm;
        blink_mask = km;
        lz_en      = lz;
        load       = 1'b1;
        @(negedge light_clk);
        load = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [27:0] actual,
                               input logic [27:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_hex_static"}, hex_static, 28'hFFFFFFF);
        checkOutput({tag, "_scan_an"}, {24'd0, scan_an}, 28'hF);
        checkOutput({tag, "_scan_seg"}, {21'd0, scan_seg}, 28'h7F);
        checkOutput({tag, "_frame_tick"}, {27'd0, frame_tick}, 28'h0);
    endtask

    initial begin
        logic [6:0]  exp_d0;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic [6:0]  slot_pat [4];
        logic        blink_on;
        int          slot;
        int          pos;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        load       = 1'b0;
        value      = '0;
        blank_mask = '0;
        dash_mask  = '0;
        blink_mask = '0;
        lz_en      = 1'b0;

        vecs[0]  = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {S1, S2, SA, SF}};
        vecs[1]  = '{16'h0005, 4'b0000, 4'b0000, 1'b1, {BL, BL, BL, S5}};
        vecs[2]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {BL, BL, BL, S0}};
        vecs[3]  = '{16'h0105, 4'b0000, 4'b0000, 1'b1, {BL, S1, S0, S5}};
        vecs[4]  = '{16'h0000, 4'b0100, 4'b0100, 1'b1, {BL, DA, BL, S0}};
        vecs[5]  = '{16'h0000, 4'b0000, 4'b0000, 1'b0, {S0, S0, S0, S0}};
        vecs[6]  = '{16'h3456, 4'b1010, 4'b0000, 1'b0, {BL, S4, BL, S6}};
        vecs[7]  = '{16'h789B, 4'b0000, 4'b0001, 1'b0, {S7, S8, S9, DA}};
        vecs[8]  = '{16'hCDE0, 4'b0000, 4'b0000, 1'b1, {SC, SD_, SE, S0}};
        vecs[9]  = '{16'h1000, 4'b1000, 4'b0000, 1'b1, {BL, S0, S0, S0}};
        vecs[10] = '{16'h0070, 4'b0000, 4'b1000, 1'b1, {DA, BL, S7, S0}};
        vecs[11] = '{16'h000B, 4'b0000, 4'b0000, 1'b0, {S0, S0, S0, SB}};

        // Reset state while rst is held
        @(negedge light_clk);
        @(negedge light_clk);
        checkResetState("reset");
        rst = 1'b0;

        // Static decode table
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].value, vecs[i].blank, vecs[i].dash, 4'b0000,
                          vecs[i].lz);
            @(negedge light_clk);
            checkOutput($sformatf("vec%0d_hex_static", i), hex_static,
                        vecs[i].expected);
        end

        // Asynchronous reset between clock edges
        @(negedge light_clk);
        #2 rst = 1'b1;
        #1 checkResetState("async_reset");

        // Scan timeline: release reset with a load already pending on edge 1
        slot_pat[0] = SF;
        slot_pat[1] = SA;
        slot_pat[2] = S2;
        slot_pat[3] = S1;
        @(negedge light_clk);
        value      = 16'h12AF;
        blank_mask = '0;
        dash_mask  = '0;
        blink_mask = '0;
        lz_en      = 1'b0;
        load       = 1'b1;
        rst        = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge light_clk);
            if (k == 1) load = 1'b0;
            slot = ((k - 1) / SD) % ND;
            pos  = (k - 1) % SD;
            if (pos == SD - 1) begin
                exp_an  = 4'b1111;
                exp_seg = BL;
            end else begin
                exp_an  = ~(4'b0001 << slot);
                exp_seg = (k == 1) ? S0 : slot_pat[slot];
            end
            checkOutput($sformatf("scan_an_k%0d", k), {24'd0, scan_an}, {24'd0, exp_an});
            checkOutput($sformatf("scan_seg_k%0d", k), {21'd0, scan_seg}, {21'd0, exp_seg});
            checkOutput($sformatf("frame_tick_k%0d", k), {27'd0, frame_tick},
                        {27'd0, (k % 16) == 0});
        end

        // Blink timeline on digit 0
        @(negedge light_clk);
        rst = 1'b1;
        @(negedge light_clk);
        value      = 16'h12AF;
        blink_mask = 4'b0001;
        load       = 1'b1;
        rst        = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge light_clk);
            if (k == 1) load = 1'b0;
`ifdef HEX_SCAN_BLINK_EN
            blink_on = (((k - 1) / 32) % 2) == 0;
`else
            blink_on = 1'b1;
`endif
            exp_d0 = blink_on ? SF : BL;
            if (k == 1) begin
                checkOutput("blink_hex_k1", hex_static, {S0, S0, S0, S0});
            end else begin
                checkOutput($sformatf("blink_hex_k%0d", k), hex_static,
                            {S1, S2, SA, exp_d0});
            end
            slot = ((k - 1) / SD) % ND;
            pos  = (k - 1) % SD;
            if (slot == 0 && pos != SD - 1) begin
                checkOutput($sformatf("blink_scan_k%0d", k), {21'd0, scan_seg},
                            {21'd0, (k == 1) ? S0 : exp_d0});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Parametrised seven-segment display engine for the CPU board. It takes a packed hex value plus per-digit masks and latches them into a shadow register on a load strobe. It drives two outputs: a registered static segment bus (one 7-bit group per digit) and a time-multiplexed scan port (one shared segment bus plus one-hot anodes). It adds leading-zero suppression, per-digit dash/blank/blink, and a frame tick. It sits between the CPU datapath/controller outputs and the board HEX/LED pins.

## Interface
- NUM_DIGITS, 8, number of digits; legal range 1..16
- SCAN_DIV, 1000, light_clk cycles per scan slot; minimum 2
- BLINK_DIV, 25, scan frames per blink half-period; minimum 1
- light_clk  in  1  sole clock; all flops rise on its posedge
- rst  in  1  asynchronous, active-high reset
- value  in  NUM_DIGITS*4  nibble i = digit i; digit 0 is least significant
- load  in  1  when high at a posedge, all inputs below are captured into the shadow register
- blank_mask  in  NUM_DIGITS  forces the digit blank
- dash_mask  in  NUM_DIGITS  forces the digit to show '-'
- blink_mask  in  NUM_DIGITS  digit blinks
- lz_en  in  1  enables leading-zero suppression
- hex_static  out  NUM_DIGITS*7  bits [7i+6:7i] drive digit i
- scan_seg  out  7  shared segment bus for the scan port
- scan_an  out  NUM_DIGITS  anode selects, one-hot, active-low
- frame_tick  out  1  one-cycle pulse at the end of each full scan

## Operation
- Segment encoding: active-low, bit order {g,f,e,d,c,b,a}.
  - Digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Digits A–F: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Blank = 1111111; dash = 0111111.
- Shadow register holds value, the three masks and lz_en. It updates only on load; all display paths read the shadow, never the live inputs.
- Per-digit priority, highest first: dash, blank, blink-off, leading-zero, hex.
- Leading-zero rule: digit i (i>0) is suppressed when lz_en=1 and shadow nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - Masks do not affect the zero test.
- Scan sequencer:
  - The prescaler counts 0..SCAN_DIV-1.
  - At each prescaler wrap, the slot index advances; it wraps from NUM_DIGITS-1 to 0.
- Blink control:
  - blink_phase resets to on.
  - A frame counter counts frame_tick pulses and toggles blink_phase on the BLINK_DIV-th tick, then clears.
  - Digits with blink_mask set display blank while the phase is off.
- load does not restart the scan, the prescaler or the blink phase.

## Timing
- Reset values:
  - hex_static: all 1s.
  - scan_seg = 1111111.
  - scan_an: all 1s.
  - frame_tick = 0.
  - Shadow register: 0.
  - Slot index, prescaler and frame counter: 0.
  - blink_phase: on.
- Reset asserted mid-operation forces all of the above immediately (asynchronously). Display resumes on the first posedge after release.
- hex_static latency: load sampled at edge k puts new shadow contents in place at edge k; hex_static reflects them at edge k+1.
- Scan port, on every posedge:
  - Prescaler ≠ SCAN_DIV-1: scan_an <= ~(1<<idx), and scan_seg <= the decoded pattern for digit idx.
  - Prescaler = SCAN_DIV-1 (dead cycle): scan_an <= all 1s, scan_seg <= 1111111, idx advances, prescaler <= 0.
  - Each digit is lit for SCAN_DIV-1 cycles out of every SCAN_DIV.
- frame_tick is registered and is high for the cycle after the dead-cycle edge on which idx wraps from NUM_DIGITS-1 to 0. Period = NUM_DIGITS*SCAN_DIV cycles.
- A load during a lit slot changes scan_seg on the next edge, with no glitch to the anodes.
- A blink toggle coincident with a load applies the new phase to the new shadow contents.

## Configuration
- HEX_SCAN_BLINK_EN defined: blink counter, blink_phase and blink_mask are all active, as described above.
- HEX_SCAN_BLINK_EN undefined:
  - No blink counter or phase flops are built.
  - blink_mask is still captured into the shadow but ignored.
  - Digits are never blanked by blink.
  - Everything else is unchanged.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2.
- Assert rst, then release -> hex_static = 28'hFFFFFFF, scan_an = 1111, scan_seg = 1111111, frame_tick = 0. Asserting rst again mid-scan returns all outputs to these values without waiting for a clock edge.
- load with value=16'h12AF and all masks 0 -> one edge after capture, digit3=1111001, digit2=0100100, digit1=0001000, digit0=0001110.
- lz_en=1:
  - value=16'h0005 -> digits 3..1 = 1111111, digit0 = 0010010.
  - value=16'h0000 -> digit0 = 1000000.
  - value=16'h0105 -> digit3 blank, digits 2..0 shown.
- Scan after reset, value=16'h12AF -> scan_an = 1110 for 3 cycles, 1111 for 1 cycle, then 1101 with scan_seg = 0001000; frame_tick pulses every 16 cycles.
- blink_mask=0001 with HEX_SCAN_BLINK_EN -> digit0 shown for 32 cycles, then blank for 32 cycles, repeating on both hex_static and the scan port. With the macro undefined -> digit0 always shown.
- dash_mask=0100 and blank_mask=0100 with lz_en=1 and value=16'h0000 -> digit2 = 0111111 (dash wins over blank and leading-zero).
